// File: rtl/ttl_decoder_scan_scheduler_pkg.sv
// Shared definitions for the 74155-style decoder scan scheduler: FSM encoding,
// the all-enables-off pin pattern and small helpers.
package ttl_decoder_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

  // Pin order {Enable1C, Enable1G_bar, Enable2C_bar, Enable2G_bar}, both blocks off
  localparam logic [3:0] ENABLES_OFF = 4'b0111;

  function automatic int calc_width_in(input int width_out);
    return (width_out < 2) ? 1 : $clog2(width_out);
  endfunction

  // mask[0] = bank 1 (block 1), mask[1] = bank 2 (block 2)
  function automatic logic [3:0] enables_from_mask(input logic [1:0] mask);
    return {mask[0], ~mask[0], ~mask[1], ~mask[1]};
  endfunction

endpackage

// File: rtl/ttl_decoder_scan_scheduler_if.sv
// Bus between the requesters and the scheduler: request levels in, decoder
// pins, one-hot grants and busy out, plus the FSM state for observation.
interface ttl_decoder_scan_scheduler_if #(
  parameter int WIDTH_OUT = 8
);
  import ttl_decoder_scan_scheduler_pkg::*;

  localparam int WIDTH_IN = calc_width_in(WIDTH_OUT);

  // Level protocol, no valid/ready: a requester holds its Request_2D bit high for
  // as long as it wants the line; its Grant_2D bit high is the acknowledge, and a
  // request dropped mid-grant releases that bank on the next edge.
  logic [2*WIDTH_OUT-1:0] Request_2D;
  logic [WIDTH_IN-1:0]    A;
  logic                   Enable1C;
  logic                   Enable1G_bar;
  logic                   Enable2C_bar;
  logic                   Enable2G_bar;
  logic [2*WIDTH_OUT-1:0] Grant_2D;
  logic                   Busy;
  sched_state_e           dbg_state;

  modport master (
    input  Request_2D,
    output A, Enable1C, Enable1G_bar, Enable2C_bar, Enable2G_bar,
    output Grant_2D, Busy, dbg_state
  );

  modport slave (
    output Request_2D,
    input  A, Enable1C, Enable1G_bar, Enable2C_bar, Enable2G_bar,
    input  Grant_2D, Busy, dbg_state
  );

endinterface

// File: rtl/ttl_decoder_scan_scheduler_rr_pick.sv
// Combinational round-robin finder: first set candidate at or above i_ptr,
// wrapping modulo N (N is a power of two, so index arithmetic wraps naturally).
module ttl_rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_cand,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest candidate is written last
  always_comb begin
    o_found = 1'b0;
    o_index = i_ptr;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = i_ptr + IW'(k);
      if (i_cand[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/ttl_decoder_scan_scheduler.sv
// Time-shares one dual 2/3-line-to-N decoder between two banks of requesters;
// a single address is selected at a time, with both banks enabled when both ask.
module ttl_decoder_scan_scheduler
  import ttl_decoder_scan_scheduler_pkg::*;
#(
  parameter int WIDTH_OUT  = 8,
  parameter int DWELL      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                          Clk,
  input  logic                          Clear,
  ttl_decoder_scan_scheduler_if.master  bus
);

  localparam int WIDTH_IN = calc_width_in(WIDTH_OUT);
  localparam int CW       = $clog2(DWELL + 1);
  localparam int GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // Rise/fall delays describe the discrete part; clocked outputs here carry none
  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_nonzero_delay
  end

  sched_state_e           r_state;
  logic [WIDTH_IN-1:0]    r_a;
  logic [WIDTH_IN-1:0]    r_ptr;
  logic [CW-1:0]          r_cnt;
  logic [GW-1:0]          r_gap;
  logic [1:0]             r_mask;
  logic [3:0]             r_en;
  logic [2*WIDTH_OUT-1:0] r_grant;
  logic                   r_busy;

  logic [WIDTH_OUT-1:0]   w_req_lo;
  logic [WIDTH_OUT-1:0]   w_req_hi;
  logic [WIDTH_OUT-1:0]   w_cand;
  logic [WIDTH_IN-1:0]    w_a_next;
  logic [WIDTH_IN-1:0]    w_pick_ptr;
  logic [WIDTH_IN-1:0]    w_pick_idx;
  logic                   w_found;
  logic [1:0]             w_new_mask;
  logic [1:0]             w_hold_mask;
  logic                   w_grant_end;

  function automatic logic [2*WIDTH_OUT-1:0] grant_vec(input logic [WIDTH_IN-1:0] a,
                                                       input logic [1:0] m);
    logic [WIDTH_OUT-1:0] one;
    one    = '0;
    one[a] = 1'b1;
    return {one & {WIDTH_OUT{m[1]}}, one & {WIDTH_OUT{m[0]}}};
  endfunction

  assign w_req_lo    = bus.Request_2D[WIDTH_OUT-1:0];
  assign w_req_hi    = bus.Request_2D[2*WIDTH_OUT-1:WIDTH_OUT];
  assign w_cand      = w_req_lo | w_req_hi;
  assign w_a_next    = r_a + WIDTH_IN'(1);
  // Leaving GRANT with no gap arbitrates from the already-advanced pointer
  assign w_pick_ptr  = (r_state == ST_GRANT) ? w_a_next : r_ptr;
  assign w_new_mask  = {w_req_hi[w_pick_idx], w_req_lo[w_pick_idx]};
  assign w_hold_mask = r_mask & {w_req_hi[r_a], w_req_lo[r_a]};
  assign w_grant_end = (w_hold_mask == 2'b00) || (r_cnt == CW'(DWELL));

  ttl_rr_pick #(
    .N  (WIDTH_OUT),
    .IW (WIDTH_IN)
  ) u_pick (
    .i_cand  (w_cand),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_index (w_pick_idx)
  );

  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_mask  <= 2'b00;
      r_en    <= ENABLES_OFF;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_a     <= w_pick_idx;
            r_mask  <= w_new_mask;
            r_en    <= enables_from_mask(w_new_mask);
            r_grant <= grant_vec(w_pick_idx, w_new_mask);
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_grant_end) begin
            r_ptr   <= w_a_next;
            r_mask  <= 2'b00;
            r_en    <= ENABLES_OFF;
            r_grant <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= ST_GAP;
              r_gap   <= GW'(1);
            end else if (w_found) begin
              r_state <= ST_GRANT;
              r_a     <= w_pick_idx;
              r_mask  <= w_new_mask;
              r_en    <= enables_from_mask(w_new_mask);
              r_grant <= grant_vec(w_pick_idx, w_new_mask);
              r_cnt   <= CW'(1);
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            // Banks can only leave a grant, never join one
            r_mask  <= w_hold_mask;
            r_en    <= enables_from_mask(w_hold_mask);
            r_grant <= grant_vec(r_a, w_hold_mask);
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == GW'(GAP_CYCLES)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_en    <= ENABLES_OFF;
          r_grant <= '0;
          r_mask  <= 2'b00;
        end
      endcase
    end
  end

  assign bus.A            = r_a;
  assign bus.Enable1C     = r_en[3];
  assign bus.Enable1G_bar = r_en[2];
  assign bus.Enable2C_bar = r_en[1];
  assign bus.Enable2G_bar = r_en[0];
  assign bus.Grant_2D     = r_grant;
  assign bus.Busy         = r_busy;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_ttl_decoder_scan_scheduler.sv
// Bench for the decoder scan scheduler: one instance with a 1-cycle gap and one
// with no gap, both driven with the same requests and checked every cycle.
module tb_ttl_decoder_scan_scheduler;
  import ttl_decoder_scan_scheduler_pkg::*;

  localparam int W     = 8;
  localparam int DWELL = 4;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Clear = 1'b1;
  always #5 Clk = ~Clk;

  ttl_decoder_scan_scheduler_if #(.WIDTH_OUT(W)) bus0 ();
  ttl_decoder_scan_scheduler_if #(.WIDTH_OUT(W)) bus1 ();

  ttl_decoder_scan_scheduler #(
    .WIDTH_OUT(W), .DWELL(DWELL), .GAP_CYCLES(1), .DELAY_RISE(0), .DELAY_FALL(0)
  ) u_dut0 (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus0)
  );

  ttl_decoder_scan_scheduler #(
    .WIDTH_OUT(W), .DWELL(DWELL), .GAP_CYCLES(0), .DELAY_RISE(0), .DELAY_FALL(0)
  ) u_dut1 (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 granting, 2 gap; used = cycles the current grant has been shown
  int m_mode[2], m_a[2], m_ptr[2], m_used[2], m_gap_left[2];
  bit m_on1[2], m_on2[2];
  int gap_cfg[2] = '{1, 0};

  task automatic model_arb(input int k, input logic [15:0] req);
    m_mode[k] = 0;
    m_on1[k]  = 0;
    m_on2[k]  = 0;
    for (int s = 0; s < W; s++) begin
      int i = (m_ptr[k] + s) % W;
      if (req[i] || req[W+i]) begin
        m_a[k]    = i;
        m_on1[k]  = req[i];
        m_on2[k]  = req[W+i];
        m_mode[k] = 1;
        m_used[k] = 1;
        break;
      end
    end
  endtask

  task automatic model_step(input int k, input logic [15:0] req, input logic clr);
    bit keep1, keep2;
    if (clr) begin
      m_mode[k] = 0; m_a[k] = 0; m_ptr[k] = 0; m_used[k] = 0; m_gap_left[k] = 0;
      m_on1[k] = 0; m_on2[k] = 0;
    end else if (m_mode[k] == 0) begin
      model_arb(k, req);
    end else if (m_mode[k] == 1) begin
      keep1 = m_on1[k] && req[m_a[k]];
      keep2 = m_on2[k] && req[W+m_a[k]];
      if ((!keep1 && !keep2) || m_used[k] == DWELL) begin
        m_ptr[k] = (m_a[k] + 1) % W;
        m_on1[k] = 0;
        m_on2[k] = 0;
        if (gap_cfg[k] > 0) begin
          m_mode[k]     = 2;
          m_gap_left[k] = gap_cfg[k];
        end else begin
          model_arb(k, req);
        end
      end else begin
        m_on1[k] = keep1;
        m_on2[k] = keep2;
        m_used[k]++;
      end
    end else begin
      m_gap_left[k]--;
      if (m_gap_left[k] == 0) m_mode[k] = 0;
    end
  endtask

  task automatic check_dut(input int k, input logic [2:0] a, input logic [3:0] en,
                           input logic [15:0] gnt, input logic busy, input sched_state_e st);
    logic [15:0] exp_g;
    exp_g = '0;
    if (m_on1[k]) exp_g[m_a[k]] = 1'b1;
    if (m_on2[k]) exp_g[W+m_a[k]] = 1'b1;
    check_eq($sformatf("d%0d_A", k), a, m_a[k]);
    check_eq($sformatf("d%0d_enables", k), en, {m_on1[k], !m_on1[k], !m_on2[k], !m_on2[k]});
    check_eq($sformatf("d%0d_grant", k), gnt, exp_g);
    check_eq($sformatf("d%0d_busy", k), busy, m_mode[k] != 0);
    check_eq($sformatf("d%0d_state_idle", k), st == ST_IDLE, m_mode[k] == 0);
  endtask

  function automatic logic [3:0] en0();
    return {bus0.Enable1C, bus0.Enable1G_bar, bus0.Enable2C_bar, bus0.Enable2G_bar};
  endfunction

  function automatic logic [3:0] en1();
    return {bus1.Enable1C, bus1.Enable1G_bar, bus1.Enable2C_bar, bus1.Enable2G_bar};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [15:0] req, input logic clr);
    logic [2:0] prev_a1;
    bus0.Request_2D = req;
    bus1.Request_2D = req;
    Clear           = clr;
    prev_a1         = bus1.A;
    @(posedge Clk);
    model_step(0, req, clr);
    model_step(1, req, clr);
    #1;
    check_dut(0, bus0.A, en0(), bus0.Grant_2D, bus0.Busy, bus0.dbg_state);
    check_dut(1, bus1.A, en1(), bus1.Grant_2D, bus1.Busy, bus1.dbg_state);
    if (m_mode[1] == 1 && m_used[1] > 1)
      check_eq("d1_A_held_in_grant", bus1.A, prev_a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [15:0]  prev_g;
    logic [15:0]  rreq;
    int           cnt;
    int           hold;

    bus0.Request_2D = '0;
    bus1.Request_2D = '0;

    // Test 1: reset with every request high
    step(16'hFFFF, 1'b1);
    step(16'hFFFF, 1'b1);
    check_eq("t1_A", bus0.A, 0);
    check_eq("t1_enables", en0(), 4'b0111);
    check_eq("t1_grant", bus0.Grant_2D, 0);
    check_eq("t1_busy", bus0.Busy, 0);

    // Test 2: dual-bank grant at address 2, held
    step(16'h0404, 1'b1);
    step(16'h0404, 1'b0);
    check_eq("t2_A", bus0.A, 2);
    check_eq("t2_enables", en0(), 4'b1000);
    check_eq("t2_grant", bus0.Grant_2D, 16'h0404);
    cnt = (bus0.Grant_2D == 16'h0404) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(16'h0404, 1'b0);
      if (bus0.Grant_2D == 16'h0404) cnt++;
      else break;
    end
    check_eq("t2_dwell_cycles", cnt, DWELL);
    check_eq("t2_gap_busy", bus0.Busy, 1);
    check_eq("t2_gap_enables", en0(), 4'b0111);
    step(16'h0404, 1'b0);
    step(16'h0404, 1'b0);
    check_eq("t2_regrant", bus0.Grant_2D, 16'h0404);

    // Test 3: fairness among 1, 5, 7 on bank 1
    step(16'h0000, 1'b1);
    exp_q = '{8'd1, 8'd5, 8'd7, 8'd1};
    obs_q = {};
    prev_g = '0;
    for (int i = 0; i < 30; i++) begin
      step(16'h00A2, 1'b0);
      if (bus0.Grant_2D != 0 && prev_g == 0) obs_q.push_back(W'(bus0.A));
      prev_g = bus0.Grant_2D;
    end
    foreach (exp_q[i])
      check_eq($sformatf("t3_order_%0d", i), (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF,
               exp_q[i]);

    // Test 4: early release of bank 2, then bank 1
    step(16'h0000, 1'b1);
    step(16'h0808, 1'b0);
    step(16'h0008, 1'b0);
    check_eq("t4_bank2_off_en", en0(), 4'b1011);
    check_eq("t4_bank1_grant", bus0.Grant_2D, 16'h0008);
    step(16'h0000, 1'b0);
    check_eq("t4_early_gap_busy", bus0.Busy, 1);
    check_eq("t4_early_gap_grant", bus0.Grant_2D, 0);

    // Test 5: late join ignored, then clear mid-grant
    step(16'h0000, 1'b1);
    step(16'h0008, 1'b0);
    step(16'h0808, 1'b0);
    check_eq("t5_no_join_grant", bus0.Grant_2D, 16'h0008);
    check_eq("t5_no_join_en", en0(), 4'b1011);
    step(16'h0808, 1'b1);
    check_eq("t5_clear_en", en0(), 4'b0111);
    check_eq("t5_clear_busy", bus0.Busy, 0);
    check_eq("t5_clear_grant", bus0.Grant_2D, 0);
    step(16'h0808, 1'b0);

    // Test 6: two requesters, zero-gap instance never idles
    step(16'h0000, 1'b1);
    step(16'h0011, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(16'h0011, 1'b0);
      if (!bus1.Busy) cnt++;
    end
    check_eq("t6_idle_cycles", cnt, 0);

    // Randomized traffic with occasional clears
    step(16'h0000, 1'b1);
    for (int i = 0; i < 80; i++) begin
      rreq = 16'($urandom() & $urandom() & $urandom());
      hold = $urandom_range(1, 6);
      for (int j = 0; j < hold; j++)
        step(rreq, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
